// File: rtl/long_sync_ctrl_if.sv
// Signal bundle between the long-preamble sync control stage and its
// neighbours: the packet controller, the peak-picker and the FFT input.
interface long_sync_ctrl_if #(
  parameter int GP_COUNTER_WIDTH = 8,
  parameter int DATA_WIDTH       = 16
);
  logic                        start;
  logic                        abort;
  logic [7:0]                  num_sym;
  logic                        in_strobe;
  logic [DATA_WIDTH-1:0]       in_I;
  logic [DATA_WIDTH-1:0]       in_Q;
  logic [GP_COUNTER_WIDTH-1:0] fm_index;
  logic                        fm_enable;
  logic [GP_COUNTER_WIDTH-1:0] fm_counter;
  logic                        out_strobe;
  logic [DATA_WIDTH-1:0]       out_I;
  logic [DATA_WIDTH-1:0]       out_Q;
  logic                        out_sym_start;
  logic [GP_COUNTER_WIDTH-1:0] peak_idx;
  logic                        sync_done;
  logic                        sync_fail;

  // Environment side: packet control, sample source and peak-picker result.
  modport master (
    output start, abort, num_sym, in_strobe, in_I, in_Q, fm_index,
    input  fm_enable, fm_counter, out_strobe, out_I, out_Q, out_sym_start,
           peak_idx, sync_done, sync_fail
  );

  // Control stage side.
  modport slave (
    input  start, abort, num_sym, in_strobe, in_I, in_Q, fm_index,
    output fm_enable, fm_counter, out_strobe, out_I, out_Q, out_sym_start,
           peak_idx, sync_done, sync_fail
  );
endinterface

// File: rtl/long_sync_ctrl.sv
// Long-preamble sync control: runs the peak search window, latches the peak,
// waits for the first symbol boundary, then strips the cyclic prefix and
// forwards the FFT body of each symbol with a symbol-start flag.
module long_sync_ctrl #(
  parameter int GP_COUNTER_WIDTH = 8,
  parameter int DATA_WIDTH       = 16,
  parameter int SEARCH_LEN       = 160,
  parameter int PEAK_TO_SYM      = 128,
  parameter int CP_LEN           = 16,
  parameter int FFT_LEN          = 64
) (
  input logic             CLK,
  input logic             a_RST_n,
  long_sync_ctrl_if.slave bus
);
  localparam int SYM_LEN = CP_LEN + FFT_LEN;
  localparam int CW      = GP_COUNTER_WIDTH + 2;
  localparam int PW      = $clog2(SYM_LEN + 1);

  localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_LEN - 1);
  localparam logic [CW-1:0] PEAK_OFS    = CW'(PEAK_TO_SYM);
  localparam logic [PW-1:0] CP_POS      = PW'(CP_LEN);
  localparam logic [PW-1:0] LAST_POS    = PW'(SYM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_LATCH,
    S_ALIGN,
    S_TRACK
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]               cnt;
  logic [CW-1:0]               target;
  logic [PW-1:0]               pos;
  logic [7:0]                  sym;
  logic [GP_COUNTER_WIDTH-1:0] peak_q;
  logic                        out_strobe_q;
  logic                        out_sym_start_q;
  logic [DATA_WIDTH-1:0]       out_i_q;
  logic [DATA_WIDTH-1:0]       out_q_q;
  logic                        done_q;
  logic                        fail_q;

  logic fm_en;
  logic cnt_inc;
  logic latch_c;
  logic trk_c;
  logic fwd;
  logic done_c;
  logic fail_c;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    fm_en     = 1'b0;
    cnt_inc   = 1'b0;
    latch_c   = 1'b0;
    trk_c     = 1'b0;
    fail_c    = 1'b0;
    done_c    = 1'b0;
    fwd       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        fm_en   = 1'b1;
        cnt_inc = bus.in_strobe;
        if (bus.in_strobe && cnt == SEARCH_LAST) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        fm_en     = 1'b1;
        latch_c   = 1'b1;
        cnt_inc   = bus.in_strobe;
        state_nxt = S_ALIGN;
      end
      S_ALIGN: begin
        cnt_inc = bus.in_strobe;
        // cnt never passes target while waiting, so this only fires on entry.
        if (target < cnt) begin
          fail_c    = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.in_strobe && cnt == target) begin
          // The boundary sample itself is pos 0 of the first symbol.
          trk_c     = 1'b1;
          state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        trk_c = bus.in_strobe;
      end
      default: state_nxt = S_IDLE;
    endcase

    fwd = trk_c && (pos >= CP_POS);
    if (trk_c && pos == LAST_POS && bus.num_sym != 8'd0 &&
        sym == bus.num_sym - 8'd1) begin
      done_c    = 1'b1;
      state_nxt = S_IDLE;
    end

    // Abort wins over everything, including a start pulse in IDLE.
    if (bus.abort) begin
      state_nxt = S_IDLE;
      cnt_inc   = 1'b0;
      latch_c   = 1'b0;
      trk_c     = 1'b0;
      fwd       = 1'b0;
      done_c    = 1'b0;
      fail_c    = 1'b0;
    end
  end

  // Sample counter, peak/target latch, symbol position and registered outputs.
  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) begin
      cnt             <= '0;
      target          <= '0;
      pos             <= '0;
      sym             <= '0;
      peak_q          <= '0;
      out_strobe_q    <= 1'b0;
      out_sym_start_q <= 1'b0;
      out_i_q         <= '0;
      out_q_q         <= '0;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
    end else begin
      if (state == S_IDLE) cnt <= '0;
      else if (cnt_inc)    cnt <= cnt + CW'(1);

      if (latch_c) begin
        peak_q <= bus.fm_index;
        target <= CW'(bus.fm_index) + PEAK_OFS;
      end

      if (state == S_IDLE) begin
        pos <= '0;
        sym <= '0;
      end else if (trk_c) begin
        if (pos == LAST_POS) begin
          pos <= '0;
          sym <= sym + 8'd1;
        end else begin
          pos <= pos + PW'(1);
        end
      end

      out_strobe_q    <= fwd;
      out_sym_start_q <= fwd && (pos == CP_POS);
      if (fwd) begin
        out_i_q <= bus.in_I;
        out_q_q <= bus.in_Q;
      end
      done_q <= done_c;
      fail_q <= fail_c;
    end
  end

  assign bus.fm_enable     = fm_en;
  assign bus.fm_counter    = cnt[GP_COUNTER_WIDTH-1:0];
  assign bus.out_strobe    = out_strobe_q;
  assign bus.out_sym_start = out_sym_start_q;
  assign bus.out_I         = out_i_q;
  assign bus.out_Q         = out_q_q;
  assign bus.peak_idx      = peak_q;
  assign bus.sync_done     = done_q;
  assign bus.sync_fail     = fail_q;
endmodule

// File: tb/tb_long_sync_ctrl.sv
// Directed bench for long_sync_ctrl. dut_a runs the default parameters,
// dut_b uses PEAK_TO_SYM=16 so the boundary lands behind the search window.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_long_sync_ctrl;
  logic CLK = 1'b0;
  logic a_RST_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_i;
  logic [15:0] exp_q;

  always #5 CLK = ~CLK;

  long_sync_ctrl_if #(.GP_COUNTER_WIDTH(8), .DATA_WIDTH(16)) bus_a ();
  long_sync_ctrl_if #(.GP_COUNTER_WIDTH(8), .DATA_WIDTH(16)) bus_b ();

  long_sync_ctrl dut_a (
    .CLK     (CLK),
    .a_RST_n (a_RST_n),
    .bus     (bus_a.slave)
  );

  long_sync_ctrl #(.PEAK_TO_SYM(16)) dut_b (
    .CLK     (CLK),
    .a_RST_n (a_RST_n),
    .bus     (bus_b.slave)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.num_sym = 8'd0; bus_a.in_strobe = 1'b0;
    bus_a.in_I = '0; bus_a.in_Q = '0; bus_a.fm_index = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.num_sym = 8'd0; bus_b.in_strobe = 1'b0;
    bus_b.in_I = '0; bus_b.in_Q = '0; bus_b.fm_index = '0;
  endtask

  // One packet on dut_a with peak index 40 (target 168). Strobe k carries
  // I=base+k, Q=~(base+k). gap idle cycles follow each strobe. abort_k>=0
  // raises abort together with that strobe; spurious pulses start at k=100/200.
  task automatic run_packet(input int gap, input int num, input int abort_k,
                            input int last_k, input logic spurious, input int base);
    int   rel;
    logic aborted;
    logic exp_out, exp_ss, exp_done;
    bus_a.num_sym  = 8'(num);
    bus_a.fm_index = 8'd40;
    bus_a.start    = 1'b1;
    step();
    bus_a.start    = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      if (k < 160) begin
        checks++; if (bus_a.fm_enable !== 1'b1) begin errors++; $display("FAIL search_fm_enable k=%0d got %b want 1", k, bus_a.fm_enable); end
        checks++; if (bus_a.fm_counter !== 8'(k)) begin errors++; $display("FAIL fm_counter k=%0d got %0d want %0d", k, bus_a.fm_counter, k); end
      end else if (k == 160 && gap == 0) begin
        checks++; if (bus_a.fm_enable !== 1'b1) begin errors++; $display("FAIL latch_fm_enable got %b want 1", bus_a.fm_enable); end
      end else if (k >= 161) begin
        checks++; if (bus_a.fm_enable !== 1'b0) begin errors++; $display("FAIL align_fm_enable k=%0d got %b want 0", k, bus_a.fm_enable); end
      end
      bus_a.in_strobe = 1'b1;
      bus_a.in_I      = 16'(base + k);
      bus_a.in_Q      = ~16'(base + k);
      bus_a.abort     = (k == abort_k);
      bus_a.start     = spurious && (k == 100 || k == 200);
      step();
      bus_a.in_strobe = 1'b0;
      bus_a.abort     = 1'b0;
      bus_a.start     = 1'b0;

      aborted  = (abort_k >= 0) && (k >= abort_k);
      rel      = k - 168;
      exp_out  = !aborted && (k >= 168) && (num == 0 || rel < 80 * num) && (rel % 80 >= 16);
      exp_ss   = exp_out && (rel % 80 == 16);
      exp_done = !aborted && (num != 0) && (k == 168 + 80 * num - 1);
      if (exp_out) begin
        exp_i = 16'(base + k);
        exp_q = ~16'(base + k);
      end
      checks++; if (bus_a.out_strobe !== exp_out) begin errors++; $display("FAIL out_strobe k=%0d got %b want %b", k, bus_a.out_strobe, exp_out); end
      checks++; if (bus_a.out_sym_start !== exp_ss) begin errors++; $display("FAIL out_sym_start k=%0d got %b want %b", k, bus_a.out_sym_start, exp_ss); end
      checks++; if (bus_a.sync_done !== exp_done) begin errors++; $display("FAIL sync_done k=%0d got %b want %b", k, bus_a.sync_done, exp_done); end
      checks++; if (bus_a.sync_fail !== 1'b0) begin errors++; $display("FAIL sync_fail k=%0d got %b want 0", k, bus_a.sync_fail); end
      checks++; if (bus_a.out_I !== exp_i || bus_a.out_Q !== exp_q) begin errors++; $display("FAIL out_data k=%0d got %h/%h want %h/%h", k, bus_a.out_I, bus_a.out_Q, exp_i, exp_q); end
      if (k >= 161) begin
        checks++; if (bus_a.peak_idx !== 8'd40) begin errors++; $display("FAIL peak_idx k=%0d got %0d want 40", k, bus_a.peak_idx); end
      end
      for (int g = 0; g < gap; g++) begin
        step();
        checks++; if (bus_a.out_strobe !== 1'b0 || bus_a.sync_done !== 1'b0) begin errors++; $display("FAIL gap_quiet k=%0d got strobe=%b done=%b want 0/0", k, bus_a.out_strobe, bus_a.sync_done); end
        checks++; if (bus_a.out_I !== exp_i || bus_a.out_Q !== exp_q) begin errors++; $display("FAIL gap_hold k=%0d got %h/%h want %h/%h", k, bus_a.out_I, bus_a.out_Q, exp_i, exp_q); end
      end
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    a_RST_n = 1'b0;
    exp_i = '0;
    exp_q = '0;
    repeat (3) step();
    checks++; if ({bus_a.fm_enable, bus_a.fm_counter, bus_a.out_strobe, bus_a.out_I, bus_a.out_Q, bus_a.out_sym_start, bus_a.peak_idx, bus_a.sync_done, bus_a.sync_fail} !== '0) begin errors++; $display("FAIL reset_outputs_a got nonzero want all 0"); end
    checks++; if ({bus_b.fm_enable, bus_b.out_strobe, bus_b.peak_idx, bus_b.sync_fail} !== '0) begin errors++; $display("FAIL reset_outputs_b got nonzero want all 0"); end
    a_RST_n = 1'b1;
    bus_a.in_strobe = 1'b1;
    repeat (3) step();
    bus_a.in_strobe = 1'b0;
    checks++; if (bus_a.fm_enable !== 1'b0 || bus_a.fm_counter !== 8'd0) begin errors++; $display("FAIL idle_ignores_strobe got en=%b cnt=%0d want 0/0", bus_a.fm_enable, bus_a.fm_counter); end
  endtask

  task automatic test_continuous();
    run_packet(0, 2, -1, 335, 1'b0, 16'h1000);
  endtask

  task automatic test_gapped();
    run_packet(2, 2, -1, 335, 1'b0, 16'h1000);
  endtask

  task automatic test_fail();
    int pulses;
    int first;
    logic seen_out;
    bus_b.num_sym  = 8'd1;
    bus_b.fm_index = 8'd20;
    bus_b.start    = 1'b1;
    step();
    bus_b.start    = 1'b0;
    bus_b.in_strobe = 1'b1;
    for (int k = 0; k < 160; k++) begin
      checks++; if (bus_b.fm_enable !== 1'b1) begin errors++; $display("FAIL fail_search_enable k=%0d got %b want 1", k, bus_b.fm_enable); end
      step();
    end
    pulses = 0;
    first = -1;
    seen_out = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus_b.sync_fail === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (bus_b.out_strobe !== 1'b0 || bus_b.sync_done !== 1'b0) seen_out = 1'b1;
    end
    bus_b.in_strobe = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL sync_fail_width got %0d high cycles want 1", pulses); end
    checks++; if (first < 0 || first > 2) begin errors++; $display("FAIL sync_fail_timing got cycle %0d want 0..2 after latch", first); end
    checks++; if (seen_out) begin errors++; $display("FAIL fail_no_output got out_strobe/done activity want none"); end
    checks++; if (bus_b.fm_enable !== 1'b0) begin errors++; $display("FAIL fail_idle_enable got %b want 0", bus_b.fm_enable); end
    checks++; if (bus_b.peak_idx !== 8'd20) begin errors++; $display("FAIL fail_peak_idx got %0d want 20", bus_b.peak_idx); end
  endtask

  task automatic test_abort();
    run_packet(0, 2, 198, 206, 1'b0, 16'h2000);
    run_packet(0, 2, -1, 335, 1'b0, 16'h3000);
  endtask

  task automatic test_async_reset();
    bus_a.num_sym  = 8'd2;
    bus_a.fm_index = 8'd40;
    bus_a.start    = 1'b1;
    step();
    bus_a.start    = 1'b0;
    bus_a.in_strobe = 1'b1;
    repeat (50) step();
    bus_a.in_strobe = 1'b0;
    checks++; if (bus_a.fm_enable !== 1'b1 || bus_a.fm_counter !== 8'd50) begin errors++; $display("FAIL pre_reset_search got en=%b cnt=%0d want 1/50", bus_a.fm_enable, bus_a.fm_counter); end
    #2;
    a_RST_n = 1'b0;
    #1;
    checks++; if ({bus_a.fm_enable, bus_a.fm_counter, bus_a.out_strobe, bus_a.out_I, bus_a.out_Q, bus_a.out_sym_start, bus_a.peak_idx, bus_a.sync_done, bus_a.sync_fail} !== '0) begin errors++; $display("FAIL async_reset_outputs got nonzero want all 0 before any edge"); end
    exp_i = '0;
    exp_q = '0;
    step();
    a_RST_n = 1'b1;
    bus_a.in_strobe = 1'b1;
    repeat (5) step();
    bus_a.in_strobe = 1'b0;
    checks++; if (bus_a.fm_enable !== 1'b0 || bus_a.out_strobe !== 1'b0 || bus_a.fm_counter !== 8'd0) begin errors++; $display("FAIL post_reset_idle got en=%b strobe=%b cnt=%0d want 0/0/0", bus_a.fm_enable, bus_a.out_strobe, bus_a.fm_counter); end
  endtask

  task automatic test_ignored_start();
    run_packet(0, 2, -1, 335, 1'b1, 16'h4000);
  endtask

  task automatic test_run_until_abort();
    run_packet(0, 0, 428, 436, 1'b0, 16'h5000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_fail();
    test_abort();
    test_async_reset();
    test_ignored_start();
    test_run_until_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
